// File: rtl/cpu_clk_pkg.sv
// Shared constants and types for the CPU clock-enable controller.
//   state_t         : FSM encoding, also driven to the board LEDs
//   CLK_HZ          : system clock frequency
//   DEBOUNCE_CYCLES_DEF : 20 ms of stable samples at CLK_HZ
//   WARMUP_CYCLES   : cycles after reset before edge/press events are trusted
package cpu_clk_pkg;
  typedef enum logic [1:0] {
    PAUSE   = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } state_t;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int WARMUP_CYCLES       = 3;
endpackage

// File: rtl/btn_debounce.sv
// Counter-based debouncer for an already synchronized button level.
//   clk     : system clock
//   reset   : synchronous, active-low
//   btn_s   : synchronized raw button level
//   level   : debounced level
//   press   : one-cycle pulse on a debounced 0->1 transition
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_CNT_W        = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_s,
  output logic level,
  output logic press
);
  localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_CNT_W-1:0] cnt;

  // A new level is accepted after DEBOUNCE_CYCLES consecutive samples that
  // differ from the current level (counter values 0..CNT_MAX).
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= btn_s;
        press <= btn_s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/cpu_clk_ctrl.sv
// Turns the divided slow_clk level into single-cycle CPU clock enables,
// with a paused single-step mode and a sticky halt.
//   clk        : 50 MHz system clock, sole clock
//   reset      : synchronous, active-low
//   slow_clk   : divider output level, treated as asynchronous data
//   run_mode   : 1 = free-run, 0 = paused / single-step
//   step_btn   : raw bouncy push-button, active high
//   halt_req   : CPU halt request, synchronous to clk
//   cpu_ce     : one-cycle CPU clock enable
//   step_count : cpu_ce pulses issued since reset (wraps)
//   halted     : high while STOPPED
//   state_o    : current FSM state for LEDs
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DB_CNT_W        = 20,
  parameter int STEP_CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slow_clk,
  input  logic                  run_mode,
  input  logic                  step_btn,
  input  logic                  halt_req,
  output logic                  cpu_ce,
  output logic [STEP_CNT_W-1:0] step_count,
  output logic                  halted,
  output logic [1:0]            state_o
);
  logic slow_q1, slow_s, slow_s_d, slow_rise;
  logic run_q1, run_s;
  logic btn_q1, btn_s;
  logic [1:0] warm;
  logic warm_done;
  logic db_level, db_press, press;
  state_t state, state_nxt;
  logic fire;

  assign warm_done = (warm == 2'(WARMUP_CYCLES));

  always_ff @(posedge clk) begin
    if (!reset) begin
      slow_q1   <= 1'b0;
      slow_s    <= 1'b0;
      slow_s_d  <= 1'b0;
      slow_rise <= 1'b0;
      run_q1    <= 1'b0;
      run_s     <= 1'b0;
      btn_q1    <= 1'b0;
      btn_s     <= 1'b0;
      warm      <= 2'd0;
    end else begin
      slow_q1   <= slow_clk;
      slow_s    <= slow_q1;
      slow_s_d  <= slow_s;
      // Registered edge; gated until the synchronizers have filled so a
      // level held through reset does not look like a fresh edge.
      slow_rise <= slow_s & ~slow_s_d & warm_done;
      run_q1    <= run_mode;
      run_s     <= run_q1;
      btn_q1    <= step_btn;
      btn_s     <= btn_q1;
      if (!warm_done) warm <= warm + 2'd1;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_CNT_W        (DB_CNT_W)
  ) u_db (
    .clk   (clk),
    .reset (reset),
    .btn_s (btn_s),
    .level (db_level),
    .press (db_press)
  );

  assign press = db_press & warm_done;

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    case (state)
      RUN: begin
        fire = slow_rise;
        if (!run_s) state_nxt = PAUSE;
      end
      STOPPED: begin
        fire = 1'b0;
      end
      default: begin  // PAUSE and the unused encoding
        fire = press;
        if (run_s) state_nxt = RUN;
      end
    endcase
    if (halt_req) begin
      fire      = 1'b0;
      state_nxt = STOPPED;
    end
    // Back-to-back enables are impossible from a single source; this covers
    // a press immediately followed by a slow edge across a mode change.
    if (cpu_ce) fire = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= PAUSE;
      cpu_ce     <= 1'b0;
      step_count <= '0;
    end else begin
      state  <= state_nxt;
      cpu_ce <= fire;
      if (fire) step_count <= step_count + STEP_CNT_W'(1);
    end
  end

  assign halted  = (state == STOPPED);
  assign state_o = state;
endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Downstream consumer of the slow-clock divider output on the single-cycle RISC-V FPGA build. Converts the divided `slow_clk` level into one-`clk`-cycle CPU clock-enable pulses. Adds a paused mode in which a debounced push-button single-steps the core, and a sticky halt on a CPU halt request. The CPU and its register/memory writes run on `clk` and are gated by `cpu_ce`; `slow_clk` is never used as a clock.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable `clk` samples required to accept a new button level (20 ms at 50 MHz).
DB_CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES-1.
STEP_CNT_W, 16, width of the issued-enable counter.

Ports:
clk  input  1  50 MHz system clock; sole clock.
reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on rising `clk`).
slow_clk  input  1  toggling level from the clock divider; asynchronous to logic, treated as data.
run_mode  input  1  slide switch; 1 = free-run, 0 = paused/single-step.
step_btn  input  1  raw push-button, active high, bouncy.
halt_req  input  1  CPU halt request (e.g. ebreak), synchronous to `clk`.
cpu_ce  output  1  one-cycle CPU clock enable.
step_count  output  STEP_CNT_W  number of `cpu_ce` pulses issued since reset.
halted  output  1  1 while in STOPPED.
state_o  output  2  current FSM state, for LEDs.

Behaviour:
- Reset (reset==0 at a `clk` edge) clears all flops on that edge:
  - cpu_ce=0, step_count=0, halted=0, state_o=PAUSE.
  - Synchronizers, debounced level and debounce counter all =0.
  - 2-bit warm-up counter =0.
- Applying reset mid-operation aborts everything with no extra enable pulse.
- Synchronizers: 2-FF synchronizers on slow_clk, run_mode and step_btn; downstream logic sees only the synced values (slow_s, run_s, btn_s).
- Warm-up:
  - Counter increments after reset release and saturates at 3.
  - Edge and press events are suppressed while the counter is <3, so no spurious edge from synchronizer fill.
- slow_rise = slow_s & ~slow_s_d (one `clk` cycle wide).
- Debounce (sub-module):
  - Counter clears whenever btn_s equals the debounced level.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES-1 the debounced level takes btn_s and the counter clears.
  - press = debounced 0->1 transition, one cycle wide.
  - A button held through reset is accepted as a press DEBOUNCE_CYCLES cycles after warm-up.
- FSM states: PAUSE=0, RUN=1, STOPPED=2 (3 unused; decodes to PAUSE).
  - PAUSE: fire = press. Goes to RUN when run_s==1.
  - RUN: fire = slow_rise. Goes to PAUSE when run_s==0.
  - STOPPED: fire = 0, halted=1. Leaves only on reset.
  - Any state goes to STOPPED when halt_req==1.
- Priority within one cycle:
  - halt_req beats any fire; that event produces no pulse.
  - Otherwise fire is evaluated under the current state, then the transition is taken. A press in the same cycle as run_s rising still yields a pulse.
- Latency: cpu_ce is registered and asserts exactly 1 `clk` after the cycle in which fire is computed. Never high for 2 consecutive cycles.
- step_count increments on the same edge cpu_ce is set; wraps 2^STEP_CNT_W-1 -> 0.
- Overall latency: slow_clk rising edge to cpu_ce = 4 `clk` cycles (2 sync + 1 edge register + 1 output register).

Decomposition:
- Shared package cpu_clk_pkg holds:
  - state encodings PAUSE/RUN/STOPPED (2-bit);
  - default DEBOUNCE_CYCLES and 50 MHz CLK_HZ constant;
  - WARMUP_CYCLES=3.
- One sub-module, btn_debounce: sync input, DEBOUNCE_CYCLES/DB_CNT_W params, outputs level and press pulse. It is reused for the board reset button elsewhere.
- FSM, edge detect and counters stay in cpu_clk_ctrl.

Test Plan (sim with DEBOUNCE_CYCLES=4, STEP_CNT_W=4):
- Reset held 3 cycles with slow_clk=1, run_mode=1, then released -> no cpu_ce through warm-up. The first cpu_ce occurs 4 cycles after the next slow_clk rising edge; step_count=1.
- run_mode=0, step_btn bounces 1/0/1 at 1-cycle spacing, then holds 1 for 10 cycles -> exactly one cpu_ce, step_count=1, state_o=0. Releasing the button gives no pulse.
- RUN with 20 slow_clk rising edges -> 20 cpu_ce pulses, each 1 cycle wide; step_count wraps 15->0 and ends at 4.
- halt_req=1 in the same cycle slow_rise is computed -> no cpu_ce. halted=1, state_o=2; further edges and presses are ignored until reset; after reset halted=0.
- run_mode toggles 1->0 while slow_clk keeps toggling -> pulses stop once run_s==0; a subsequent debounced press gives exactly one pulse.
- Reset asserted mid-debounce (counter=2) -> counter and level cleared, no press emitted; step_count=0 on the next cycle.
